// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait, multi-cycle MUL/DIV,
// branch redirect, load-use and fetch wait, resolved in fixed priority, plus a stall counter.
module hazard_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_is_mul,
    input  logic        ex_is_div,
    input  logic        ex_branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_stall,
    output logic        ex_mem_flush,
    output logic        muldiv_busy,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam bit              MUL_MULTI = (MUL_CYCLES > 1);
    localparam int              MUL_LOAD_I = MUL_MULTI ? (MUL_CYCLES - 2) : 0;
    localparam int              DIV_LOAD_I = (DIV_CYCLES > 1) ? (DIV_CYCLES - 2) : 0;
    localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_LOAD_I);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LOAD_I);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] load_val;
    logic             mem_wait;
    logic             entry;
    logic             muldiv;
    logic             branch;
    logic             load_use;

    assign mem_wait = !dmem_ready;
    assign entry    = (state == IDLE) && ex_valid && dmem_ready &&
                      (ex_is_div || (ex_is_mul && MUL_MULTI));
    assign muldiv   = (state == BUSY) || entry;
    assign branch   = ex_branch_taken && ex_valid;
    assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));
    assign load_val = ex_is_div ? DIV_LOAD : MUL_LOAD;

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        muldiv_busy  = 1'b0;
        if (rst) begin
            muldiv_busy = (state == BUSY);
            if (mem_wait) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
            end else if (muldiv) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (branch) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (load_use) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (!imem_ready) begin
                pc_stall     = 1'b1;
                if_id_flush  = 1'b1;
            end
        end
    end

    // The entry cycle is the first stalled cycle; the counter then holds the number of
    // BUSY cycles still to go, so an N-cycle op gives N-1 stalls plus one DONE release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            stall_cycles <= 32'd0;
        end else begin
            if (pc_stall)
                stall_cycles <= stall_cycles + 32'd1;
            case (state)
                IDLE: begin
                    if (entry) begin
                        cnt   <= load_val;
                        state <= (load_val == '0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1))
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected control vectors are queued when stimulus is
// driven and compared at the following falling edge.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_valid, ex_mem_read;
    logic        ex_is_mul, ex_is_div, ex_branch_taken, imem_ready, dmem_ready;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, ex_mem_flush, muldiv_busy;
    logic [31:0] stall_cycles;
    logic        m1_pc_stall, m1_if_id_stall, m1_if_id_flush, m1_id_ex_stall, m1_id_ex_flush;
    logic        m1_ex_mem_stall, m1_ex_mem_flush, m1_muldiv_busy;
    logic [31:0] m1_stall_cycles;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_mul(ex_is_mul),
        .ex_is_div(ex_is_div), .ex_branch_taken(ex_branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .pc_stall(pc_stall),
        .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
        .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
        .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
    );

    hazard_ctrl #(.MUL_CYCLES(1)) dut_m1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_mul(ex_is_mul),
        .ex_is_div(ex_is_div), .ex_branch_taken(ex_branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .pc_stall(m1_pc_stall),
        .if_id_stall(m1_if_id_stall), .if_id_flush(m1_if_id_flush),
        .id_ex_stall(m1_id_ex_stall), .id_ex_flush(m1_id_ex_flush),
        .ex_mem_stall(m1_ex_mem_stall), .ex_mem_flush(m1_ex_mem_flush),
        .muldiv_busy(m1_muldiv_busy), .stall_cycles(m1_stall_cycles)
    );

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush, muldiv_busy}
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_IF   = 8'b1010_0000;
    localparam logic [7:0] C_LU   = 8'b1100_1000;
    localparam logic [7:0] C_BR   = 8'b0010_1000;
    localparam logic [7:0] C_MEMW = 8'b1101_0100;
    localparam logic [7:0] C_MEMB = 8'b1101_0101;
    localparam logic [7:0] C_MD   = 8'b1101_0010;
    localparam logic [7:0] C_MDB  = 8'b1101_0011;

    typedef struct {
        logic [7:0]  ctl;
        logic [31:0] sc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_sc = 32'd0;
    logic [7:0]  obs;

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_valid = 1'b0; ex_rd = 5'd0; ex_mem_read = 1'b0; ex_is_mul = 1'b0;
        ex_is_div = 1'b0; ex_branch_taken = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    endtask

    // Inputs are already applied; compare at the falling edge, then move to just after the next rising edge.
    task automatic step(input string tag, input logic [7:0] ctl);
        exp_t e;
        e.ctl = ctl;
        e.sc  = exp_sc;
        sb.push_back(e);
        @(negedge clk);
        e   = sb.pop_front();
        obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, ex_mem_flush, muldiv_busy};
        checks++;
        assert (obs === e.ctl) else begin
            errors++;
            $error("FAIL %s ctl: observed %b expected %b", tag, obs, e.ctl);
        end
        checks++;
        assert (stall_cycles === e.sc) else begin
            errors++;
            $error("FAIL %s stall_cycles: observed %0d expected %0d", tag, stall_cycles, e.sc);
        end
        $display("step %-10s ctl=%b stall_cycles=%0d", tag, obs, stall_cycles);
        if (rst && e.ctl[7]) exp_sc = exp_sc + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_div();
        clear_inputs();
        ex_valid = 1'b1; ex_is_div = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        exp_sc = 32'd0;
        imem_ready = 1'b0;
        step("reset0", C_NONE);
        set_div();
        step("reset1", C_NONE);
        clear_inputs();
        rst = 1'b1;
        step("idle", C_NONE);

        imem_ready = 1'b0;
        step("ifwait", C_IF);

        clear_inputs();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        step("lu_rs1", C_LU);
        clear_inputs();
        id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        step("lu_after", C_NONE);

        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        step("lu_x0", C_NONE);

        clear_inputs();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
        step("lu_rs2", C_LU);
        id_use_rs2 = 1'b0; id_rs1 = 5'd9;
        step("lu_nouse", C_NONE);

        clear_inputs();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        ex_branch_taken = 1'b1;
        step("br_lu", C_BR);
        clear_inputs();
        ex_branch_taken = 1'b1; imem_ready = 1'b0;
        step("br_inval", C_IF);

        clear_inputs();
        dmem_ready = 1'b0; ex_branch_taken = 1'b1; ex_valid = 1'b1; imem_ready = 1'b0;
        step("memwait", C_MEMW);

        // MUL with default MUL_CYCLES=2: one stall, then release with the op still visible.
        clear_inputs();
        ex_valid = 1'b1; ex_is_mul = 1'b1;
        step("mul_ent", C_MD);
        checks++;
        assert ({m1_pc_stall, m1_muldiv_busy} === 2'b00) else begin
            errors++;
            $error("FAIL mul1_ent: observed %b expected 00", {m1_pc_stall, m1_muldiv_busy});
        end
        step("mul_done", C_NONE);
        clear_inputs();
        step("mul_idle", C_NONE);

        // DIV with MUL also flagged: div wins, 32 stalled cycles, then DONE.
        set_div();
        ex_is_mul = 1'b1;
        step("div_ent", C_MD);
        for (int i = 0; i < 31; i++) step("div_busy", C_MDB);
        step("div_done", C_NONE);
        clear_inputs();
        step("div_idle", C_NONE);

        // DIV with a 3-cycle memory wait in the middle.
        set_div();
        step("dw_ent", C_MD);
        for (int i = 0; i < 10; i++) step("dw_busy", C_MDB);
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("dw_mem", C_MEMB);
        dmem_ready = 1'b1;
        for (int i = 0; i < 21; i++) step("dw_busy2", C_MDB);
        step("dw_done", C_NONE);
        clear_inputs();
        step("dw_idle", C_NONE);

        // Reset while the counter is at 10.
        set_div();
        step("rb_ent", C_MD);
        for (int i = 0; i < 21; i++) step("rb_busy", C_MDB);
        rst = 1'b0;
        exp_sc = 32'd0;
        step("rb_reset", C_NONE);
        clear_inputs();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step("rb_after", C_NONE);
        imem_ready = 1'b0;
        step("rb_ifwait", C_IF);
        clear_inputs();
        step("rb_end", C_NONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
